pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer: issues imem requests, registers returned words,
// and handles stall, redirect (with misalignment trap) and halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_out,
  output logic        misalign
);

  // state   | meaning
  // S_IDLE  | one cycle after reset, no request
  // S_REQ   | fetch request outstanding at pc
  // S_HOLD  | instruction held for a stalled consumer
  // S_HALTED| fetching stopped until reset
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic        halt_pend_q, halt_pend_d;

  logic        redir_bad;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;
  logic        halt_eff;

  assign redir_bad = (redirect_target[1:0] != 2'b00);
  assign redir_pc  = redir_bad ? TRAP_VECTOR : redirect_target;
  assign pc_inc    = pc_q + 32'd4;
  assign halt_eff  = halt | halt_pend_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    misalign_d    = 1'b0;
    halt_pend_d   = halt_pend_q;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
        end
        state_d = halt ? S_HALTED : S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d        = redir_pc;
          misalign_d  = redir_bad;
          halt_pend_d = 1'b0;
          state_d     = halt_eff ? S_HALTED : S_REQ;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          if (halt_eff) begin
            // the acked word is delivered once, then fetching stops past it
            halt_pend_d = 1'b0;
            pc_d        = pc_inc;
            state_d     = S_HALTED;
          end else if (stall) begin
            state_d = S_HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
          state_d    = halt ? S_HALTED : S_REQ;
        end else if (halt) begin
          state_d = S_HALTED;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = S_REQ;
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;

endmodule
